random_scheduler: RTL and testbench

Shares the single free-running 8-bit LFSR random source (the `Random` block) among several graphics requesters, such as sprite jitter, starfield placement and noise fill. It arbitrates round-robin and enforces a minimum spacing between samples: consecutive LFSR states share WIDTH-1 bits, so back-to-back draws would be correlated. Each grant returns one decorrelated byte with a one-cycle acknowledge. It sits between the `Random` instance and the pixel-pipeline clients.

---
 rtl/random_pkg.sv | 21 ++
 rtl/random_scheduler_if.sv | 28 ++
 rtl/random_scheduler_rr_pick.sv | 52 +++++
 rtl/random_scheduler.sv | 90 +++++++++
 tb/tb_random_scheduler.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/random_pkg.sv
// ----------------------------------------------------------------------------
// random_pkg
// Shared constants for the random-source subsystem. The scheduler, its
// interface and its round-robin picker all import this package.
//   RANDOM_WIDTH    : width of the LFSR output word
//   LFSR_PERIOD     : sequence length of the 8-bit maximal LFSR
//   DEFAULT_SPACING : cycles between samples that fully shifts out a word
//   idx_width()     : index/counter width helper, never narrower than 1 bit
// ----------------------------------------------------------------------------
package random_pkg;

    localparam int RANDOM_WIDTH    = 8;
    localparam int LFSR_PERIOD     = 255;
    localparam int DEFAULT_SPACING = 8;

    // Width able to hold values 0..n-1; a 1-bit field is still needed for n<=1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/random_scheduler_if.sv
// ----------------------------------------------------------------------------
// random_scheduler_if
// Bundles the signals between the LFSR / pixel-pipeline clients and the
// random_scheduler.
//   random : current LFSR word, new value every cycle
//   req    : level request per client
//   ack    : one-hot, one-cycle grant pulse
//   data   : sampled random word, valid with ack and held afterwards
//   busy   : spacing window active, no grant can issue this cycle
// Modports: master = clients/LFSR side, slave = scheduler side.
// ----------------------------------------------------------------------------
interface random_scheduler_if
    import random_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = RANDOM_WIDTH
);

    logic [WIDTH-1:0]   random;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] ack;
    logic [WIDTH-1:0]   data;
    logic               busy;

    modport master (output random, output req, input ack, input data, input busy);
    modport slave  (input random, input req, output ack, output data, output busy);

endinterface

// File: rtl/random_scheduler_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Starting at index ptr and wrapping
// modulo NUM_REQ, the first set bit of eligible wins.
//   eligible : candidate vector
//   ptr      : index where the search starts (always < NUM_REQ)
//   grant    : one-hot of the winner, zero when nothing is eligible
//   idx      : binary index of the winner
//   any      : at least one candidate was eligible
// ----------------------------------------------------------------------------
module rr_pick
    import random_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int PW     = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      idx,
    output logic               any
);

    // One extra bit so ptr+k never overflows before the modulo fold.
    localparam int SW = PW + 1;

    logic [SW-1:0] sum;
    logic [PW-1:0] pos;

    // Walk the candidates in rotated order. NUM_REQ need not be a power of
    // two, so the wrap is an explicit subtract rather than a bit truncation.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(NUM_REQ)) begin
                sum = sum - SW'(NUM_REQ);
            end
            pos = sum[PW-1:0];
            if (!any && eligible[pos]) begin
                any        = 1'b1;
                idx        = pos;
                grant[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/random_scheduler.sv
// ----------------------------------------------------------------------------
// random_scheduler
// Shares one free-running LFSR among several requesters. Grants are issued
// round-robin and no closer than SPACING cycles apart, so successive samples
// handed out do not share shifted bits.
//   clk : system clock (the LFSR steps on the same edge)
//   rst : asynchronous, active-low reset
//   bus : random_scheduler_if slave modport (random, req in; ack, data,
//         busy out)
// ----------------------------------------------------------------------------
module random_scheduler
    import random_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = RANDOM_WIDTH,
    parameter int SPACING = DEFAULT_SPACING
) (
    input logic               clk,
    input logic               rst,
    random_scheduler_if.slave bus
);

    localparam int GW = idx_width(SPACING);
    localparam int PW = idx_width(NUM_REQ);
    localparam logic [GW-1:0] GAP_RESET = GW'(SPACING - 1);

    logic [NUM_REQ-1:0] ack_q,  ack_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [GW-1:0]      gap_q,  gap_d;
    logic [PW-1:0]      ptr_q,  ptr_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick_grant;
    logic [PW-1:0]      pick_idx;
    logic               pick_any;
    logic               grant_now;

    // A client still seeing its ack this cycle is masked out; this only has
    // an effect when SPACING is 1 and grants can land on adjacent cycles.
    assign eligible = bus.req & ~ack_q;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .grant    (pick_grant),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    assign grant_now = (gap_q == '0) && pick_any;

    // Next-state: a grant pulses ack, captures the current random word,
    // restarts the spacing window and moves the pointer past the winner.
    // Otherwise the window counts down to zero and data is held.
    always_comb begin
        ack_d  = '0;
        data_d = data_q;
        gap_d  = (gap_q == '0) ? gap_q : gap_q - GW'(1);
        ptr_d  = ptr_q;
        if (grant_now) begin
            ack_d  = pick_grant;
            data_d = bus.random;
            gap_d  = GAP_RESET;
            if (pick_idx == PW'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = pick_idx + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q  <= '0;
            data_q <= '0;
            gap_q  <= GAP_RESET;
            ptr_q  <= '0;
        end else begin
            ack_q  <= ack_d;
            data_q <= data_d;
            gap_q  <= gap_d;
            ptr_q  <= ptr_d;
        end
    end

    assign bus.ack  = ack_q;
    assign bus.data = data_q;
    assign bus.busy = (gap_q != '0);

endmodule

// File: tb/tb_random_scheduler.sv
// ----------------------------------------------------------------------------
// tb_random_scheduler
// Directed bench for random_scheduler. Two instances share clk/rst: u_dut
// with the default SPACING of 8 and u_dut1 built with SPACING of 1. Each
// driven cycle pushes the expected ack/data/busy of the following cycle to a
// scoreboard queue, which is popped and compared at the next falling edge.
// ----------------------------------------------------------------------------
module tb_random_scheduler;

    logic clk;
    logic rst;

    random_scheduler_if #(.NUM_REQ(4), .WIDTH(8)) bus0 ();
    random_scheduler_if #(.NUM_REQ(4), .WIDTH(8)) bus1 ();

    random_scheduler #(.NUM_REQ(4), .WIDTH(8), .SPACING(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    random_scheduler #(.NUM_REQ(4), .WIDTH(8), .SPACING(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Clock: rising edges at 5, 15, 25 ...; inputs change and outputs are
    // sampled on falling edges, well away from the active edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit         sel;
        logic [3:0] ack;
        logic [7:0] data;
        logic       busy;
    } exp_t;

    exp_t       sb[$];
    int         tests_run;
    int         tests_failed;
    logic [7:0] exp_data0;
    logic [7:0] exp_data1;

    // Single comparison point: counts the test and reports any difference.
    task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Pops the expectation recorded for this cycle and compares the chosen DUT.
    task automatic checkOutput(input string tag);
        exp_t e;
        e = sb.pop_front();
        if (e.sel == 1'b0) begin
            cmp({tag, " ack"},  32'(bus0.ack),  32'(e.ack));
            cmp({tag, " data"}, 32'(bus0.data), 32'(e.data));
            cmp({tag, " busy"}, 32'(bus0.busy), 32'(e.busy));
        end else begin
            cmp({tag, " ack"},  32'(bus1.ack),  32'(e.ack));
            cmp({tag, " data"}, 32'(bus1.data), 32'(e.data));
            cmp({tag, " busy"}, 32'(bus1.busy), 32'(e.busy));
        end
    endtask

    // Drives one cycle of req/random into the selected DUT, records what the
    // next cycle must show, then advances to the next falling edge to check.
    task automatic applyStimulus(input bit sel, input string tag, input logic [3:0] r,
                                 input logic [7:0] rnd, input logic [3:0] exp_ack,
                                 input logic exp_busy);
        exp_t e;
        e.sel  = sel;
        e.ack  = exp_ack;
        e.busy = exp_busy;
        if (sel == 1'b0) begin
            bus0.req    = r;
            bus0.random = rnd;
            if (exp_ack != 4'b0000) exp_data0 = rnd;
            e.data = exp_data0;
        end else begin
            bus1.req    = r;
            bus1.random = rnd;
            if (exp_ack != 4'b0000) exp_data1 = rnd;
            e.data = exp_data1;
        end
        sb.push_back(e);
        @(negedge clk);
        checkOutput(tag);
    endtask

    // The seven cycles of the spacing window after a grant on u_dut: no ack,
    // busy until the last one, random values that must not be captured.
    task automatic idleSlot(input string tag, input logic [3:0] r);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b0, tag, r, 8'($urandom), 4'b0000, (i < 7));
        end
    endtask

    // Safety net so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    // Directed sequence: reset, single grant, fairness/withdrawal, reset
    // during an ack, rotation, then the SPACING=1 instance.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_data0    = 8'h00;
        exp_data1    = 8'h00;
        rst          = 1'b0;
        bus0.req     = 4'b0000;
        bus0.random  = 8'h00;
        bus1.req     = 4'b0000;
        bus1.random  = 8'h00;

        // Reset held: outputs cleared, spacing window open on u_dut only.
        repeat (2) @(negedge clk);
        cmp("reset ack",        32'(bus0.ack),  32'h0);
        cmp("reset data",       32'(bus0.data), 32'h0);
        cmp("reset busy",       32'(bus0.busy), 32'h1);
        cmp("reset sp1 ack",    32'(bus1.ack),  32'h0);
        cmp("reset sp1 busy",   32'(bus1.busy), 32'h0);

        // Release: busy stays high for 7 cycles, no ack without requests.
        rst = 1'b1;
        cmp("release busy c0", 32'(bus0.busy), 32'h1);
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b0, "post-reset", 4'b0000, 8'($urandom), 4'b0000, (i < 7));
        end

        // Single client: immediate grant, then exactly 8 cycles to the next.
        applyStimulus(1'b0, "single grant", 4'b0010, 8'hA5, 4'b0010, 1'b1);
        idleSlot("single hold", 4'b0010);
        applyStimulus(1'b0, "single regrant", 4'b0010, 8'h3C, 4'b0010, 1'b1);
        idleSlot("single idle", 4'b0000);

        // Fairness: after client 2, pointer sits at 3 so 1000 beats 0001.
        applyStimulus(1'b0, "fair c2", 4'b0100, 8'h11, 4'b0100, 1'b1);
        idleSlot("fair idle a", 4'b1001);
        applyStimulus(1'b0, "fair 1001 first", 4'b1001, 8'h22, 4'b1000, 1'b1);
        idleSlot("fair idle b", 4'b1001);
        applyStimulus(1'b0, "fair 1001 second", 4'b1001, 8'h33, 4'b0001, 1'b1);

        // Withdrawal: 0001 raised then dropped inside the window is never acked.
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b0, "withdraw", (i <= 3) ? 4'b0001 : 4'b0000,
                          8'($urandom), 4'b0000, (i < 7));
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, "withdrawn idle", 4'b0000, 8'($urandom), 4'b0000, 1'b0);
        end

        // Reset asserted in the middle of an ack cycle clears it at once.
        applyStimulus(1'b0, "pre-reset ack", 4'b0010, 8'h5A, 4'b0010, 1'b1);
        #2 rst = 1'b0;
        #1;
        cmp("async reset ack",  32'(bus0.ack),  32'h0);
        cmp("async reset data", 32'(bus0.data), 32'h0);
        cmp("async reset busy", 32'(bus0.busy), 32'h1);
        exp_data0 = 8'h00;
        exp_data1 = 8'h00;
        bus0.req  = 4'b0000;
        @(negedge clk);
        rst = 1'b1;

        // Release with 1001 held: first ack 0001 eight cycles later, then 1000.
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b0, "post-reset2", 4'b1001, 8'($urandom), 4'b0000, (i < 7));
        end
        applyStimulus(1'b0, "reset2 first", 4'b1001, 8'h77, 4'b0001, 1'b1);
        idleSlot("reset2 idle", 4'b1001);
        applyStimulus(1'b0, "reset2 second", 4'b1001, 8'h88, 4'b1000, 1'b1);
        idleSlot("reset2 idle b", 4'b1111);

        // Rotation with everyone requesting, starting from pointer 0.
        applyStimulus(1'b0, "rot 0", 4'b1111, 8'hB0, 4'b0001, 1'b1);
        idleSlot("rot idle", 4'b1111);
        applyStimulus(1'b0, "rot 1", 4'b1111, 8'hB1, 4'b0010, 1'b1);
        idleSlot("rot idle", 4'b1111);
        applyStimulus(1'b0, "rot 2", 4'b1111, 8'hB2, 4'b0100, 1'b1);
        idleSlot("rot idle", 4'b1111);
        applyStimulus(1'b0, "rot 3", 4'b1111, 8'hB3, 4'b1000, 1'b1);
        idleSlot("rot idle", 4'b1111);
        applyStimulus(1'b0, "rot 4", 4'b1111, 8'hB4, 4'b0001, 1'b1);
        bus0.req = 4'b0000;

        // SPACING=1: a lone holder is acked every other cycle (ack mask).
        applyStimulus(1'b1, "sp1 lone a", 4'b0001, 8'hC1, 4'b0001, 1'b0);
        applyStimulus(1'b1, "sp1 lone b", 4'b0001, 8'hC2, 4'b0000, 1'b0);
        applyStimulus(1'b1, "sp1 lone c", 4'b0001, 8'hC3, 4'b0001, 1'b0);
        applyStimulus(1'b1, "sp1 lone d", 4'b0001, 8'hC4, 4'b0000, 1'b0);

        // SPACING=1: two holders alternate on consecutive cycles (ptr is 1).
        applyStimulus(1'b1, "sp1 pair a", 4'b0011, 8'hD1, 4'b0010, 1'b0);
        applyStimulus(1'b1, "sp1 pair b", 4'b0011, 8'hD2, 4'b0001, 1'b0);
        applyStimulus(1'b1, "sp1 pair c", 4'b0011, 8'hD3, 4'b0010, 1'b0);
        bus1.req = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
